// File: rtl/qspi_shift_unit_pkg.sv
// Shared encodings for the QSPI shift unit: lane modes, FSM states and beat-width decode.
// The lane-mode values match those used by the SCK generator and the controller FSM.
package qspi_shift_unit_pkg;

    typedef enum logic [1:0] {
        QSPI_X1  = 2'b00,
        QSPI_X2  = 2'b01,
        QSPI_X4  = 2'b10,
        QSPI_RSV = 2'b11
    } lane_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    // log2 of the beat width; the reserved mode falls back to single-lane operation
    function automatic logic [1:0] beat_log2(input logic [1:0] mode);
        case (mode)
            QSPI_X2: return 2'd1;
            QSPI_X4: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/qspi_shift_unit_if.sv
// Controller-side bus of the QSPI shift unit: config, SCK strobes, pad lanes and status.
interface qspi_shift_if #(
    parameter int DW  = 32,
    parameter int BCW = 2
);
    logic           start;
    logic [1:0]     lane_mode;
    logic [BCW-1:0] nbyte_m1;
    logic [DW-1:0]  tx_data;
    logic           shift_en;
    logic           sample_en;
    logic [3:0]     io_in;
    logic [3:0]     io_out;
    logic           busy;
    logic           done;
    logic [DW-1:0]  rx_data;

    modport master (
        output start, lane_mode, nbyte_m1, tx_data, shift_en, sample_en, io_in,
        input  io_out, busy, done, rx_data
    );

    modport slave (
        input  start, lane_mode, nbyte_m1, tx_data, shift_en, sample_en, io_in,
        output io_out, busy, done, rx_data
    );
endinterface

// File: rtl/qspi_shift_unit_lane_mux.sv
// Combinational lane select for W=1/2/4: places the top TX bits on the pad lanes and
// gathers the active RX lanes right-justified, higher lane = more significant bit.
module qspi_shift_unit_lane_mux (
    input  logic [1:0] wlog,
    input  logic [3:0] tx_top,
    input  logic [3:0] io_in,
    output logic [3:0] beat,
    output logic [3:0] rx_lanes
);

    always_comb begin
        beat     = '0;
        rx_lanes = '0;
        case (wlog)
            2'd1: begin
                beat[1:0]     = tx_top[3:2];
                rx_lanes[1:0] = io_in[1:0];
            end
            2'd2: begin
                beat     = tx_top;
                rx_lanes = io_in;
            end
            // single lane: MOSI on io[0], MISO returns on io[1]
            default: begin
                beat[0]     = tx_top[3];
                rx_lanes[0] = io_in[1];
            end
        endcase
    end

endmodule

// File: rtl/qspi_shift_unit.sv
// QSPI data shifter: serialises a right-justified TX word MSB-first over 1/2/4 lanes and
// rebuilds the RX word, paced by the SCK generator's shift_en/sample_en strobes.
module qspi_shift_unit
    import qspi_shift_unit_pkg::*;
#(
    parameter int DW  = 32,
    parameter int BCW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    qspi_shift_if.slave  bus
);

    localparam int CW = $clog2(DW) + 1;

    state_e        state_q, state_d;
    logic [DW-1:0] tx_q, tx_d;
    logic [DW-1:0] rx_q, rx_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    wlog_q, wlog_d;
    logic [3:0]    io_q, io_d;
    logic          done_q, done_d;

    logic [1:0]    wlog_sel;
    logic [2:0]    wsel;
    logic [CW-1:0] nbits, beats_m1;
    logic [DW-1:0] tx_load, tx_shl, rx_shl;
    logic [3:0]    beat, rx_lanes;
    logic          accept, smp, last, shf;

    // In IDLE the incoming config is what matters (start); in XFER the latched one
    assign wlog_sel = (state_q == ST_IDLE) ? beat_log2(bus.lane_mode) : wlog_q;
    assign wsel     = 3'd1 << wlog_sel;

    assign nbits    = (CW'(bus.nbyte_m1) + CW'(1)) << 3;
    assign beats_m1 = (nbits >> wlog_sel) - CW'(1);
    assign tx_load  = bus.tx_data << (CW'(DW) - nbits);
    assign tx_shl   = tx_q << wsel;
    assign rx_shl   = (rx_q << wsel) | DW'(rx_lanes);

    assign accept = (state_q == ST_IDLE) && bus.start;
    assign smp    = (state_q == ST_XFER) && bus.sample_en;
    assign last   = smp && (cnt_q == '0);
    // a launch coinciding with the final capture has nothing left to launch
    assign shf    = (state_q == ST_XFER) && bus.shift_en && !last;

    assign tx_d = accept ? tx_load : (shf ? tx_shl : tx_q);

    qspi_shift_unit_lane_mux u_lane_mux (
        .wlog     (wlog_sel),
        .tx_top   (tx_d[DW-1 -: 4]),
        .io_in    (bus.io_in),
        .beat     (beat),
        .rx_lanes (rx_lanes)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wlog_d    = wlog_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        io_d      = io_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                io_d = '0;
                if (bus.start) begin
                    state_d = ST_XFER;
                    cnt_d   = beats_m1;
                    wlog_d  = wlog_sel;
                    rx_d    = '0;
                    io_d    = beat;
                end
            end
            ST_XFER: begin
                if (shf)
                    io_d = beat;
                if (smp) begin
                    rx_d = rx_shl;
                    if (cnt_q == '0) begin
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        rx_data_d = rx_shl;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            cnt_q     <= '0;
            wlog_q    <= '0;
            io_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            cnt_q     <= cnt_d;
            wlog_q    <= wlog_d;
            io_q      <= io_d;
            done_q    <= done_d;
        end
    end

    assign bus.io_out  = io_q;
    assign bus.busy    = (state_q == ST_XFER);
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;

endmodule
